// File: rtl/pool_window_buffer_if.sv
// pool_window_buffer_if
//   Groups the pixel input stream, the 2x2 window output stream and the
//   end-of-frame pulse of pool_window_buffer into one bundle.
//   Ports (slave = the window buffer, master = the upstream/downstream side):
//     in_valid, pixel_in   : raster-scan pixel offered by upstream
//     in_ready             : buffer accepts pixel_in this cycle
//     out_valid, out1..out4: 2x2 window (TL, TR, BL, BR) offered downstream
//     out_ready            : downstream consumes the window
//     frame_done           : one-cycle pulse after the last window of a frame
interface pool_window_buffer_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] pixel_in;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out1;
  logic [DATA_WIDTH-1:0] out2;
  logic [DATA_WIDTH-1:0] out3;
  logic [DATA_WIDTH-1:0] out4;
  logic                  frame_done;

  modport slave (
    input  in_valid, pixel_in, out_ready,
    output in_ready, out_valid, out1, out2, out3, out4, frame_done
  );

  modport master (
    output in_valid, pixel_in, out_ready,
    input  in_ready, out_valid, out1, out2, out3, out4, frame_done
  );
endinterface

// File: rtl/pool_window_buffer.sv
// pool_window_buffer
//   Collects a raster-scan feature map into non-overlapping 2x2 windows
//   (stride 2) for a downstream pooling stage. Even rows are stored in a
//   one-row line buffer; odd rows pair up with it to form windows. Pixel data
//   passes through bit-exact.
//   Ports:
//     clk    : rising-edge clock
//     rst_n  : asynchronous active-low reset
//     clear  : synchronous frame restart (drops a simultaneous pixel)
//     bus    : pool_window_buffer_if slave (pixel in, window out, frame_done)
module pool_window_buffer #(
  parameter int DATA_WIDTH = 8,
  parameter int IMG_WIDTH  = 28,
  parameter int IMG_HEIGHT = 28
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear,
  pool_window_buffer_if.slave   bus
);

  localparam int COL_W = (IMG_WIDTH  > 2) ? $clog2(IMG_WIDTH)  : 1;
  localparam int ROW_W = (IMG_HEIGHT > 2) ? $clog2(IMG_HEIGHT) : 1;
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_WIDTH - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_HEIGHT - 1);

  typedef enum logic {
    FILL,
    PAIR
  } state_e;

  state_e                state_q, state_d;
  logic [COL_W-1:0]      col_q, col_d;
  logic [ROW_W-1:0]      row_q, row_d;
  logic [DATA_WIDTH-1:0] top_left_q, top_left_d;
  logic [DATA_WIDTH-1:0] bot_left_q, bot_left_d;
  logic [DATA_WIDTH-1:0] out1_q, out1_d;
  logic [DATA_WIDTH-1:0] out2_q, out2_d;
  logic [DATA_WIDTH-1:0] out3_q, out3_d;
  logic [DATA_WIDTH-1:0] out4_q, out4_d;
  logic                  out_valid_q, out_valid_d;
  logic                  last_win_q, last_win_d;
  logic                  frame_done_q, frame_done_d;

  // Line buffer has no reset: every entry is rewritten in FILL before PAIR reads it.
  logic [DATA_WIDTH-1:0] line_buf_q [IMG_WIDTH];
  logic                  lb_we;

  logic in_ready;
  logic accept;

  // A held window blocks input so that a new window can never overwrite one
  // that downstream has not taken yet.
  assign in_ready = !out_valid_q || bus.out_ready;
  assign accept   = bus.in_valid && in_ready;

  assign bus.in_ready   = in_ready;
  assign bus.out_valid  = out_valid_q;
  assign bus.out1       = out1_q;
  assign bus.out2       = out2_q;
  assign bus.out3       = out3_q;
  assign bus.out4       = out4_q;
  assign bus.frame_done = frame_done_q;

  // Next-state logic: counters, FILL/PAIR sequencing and window assembly.
  always_comb begin
    state_d      = state_q;
    col_d        = col_q;
    row_d        = row_q;
    top_left_d   = top_left_q;
    bot_left_d   = bot_left_q;
    out1_d       = out1_q;
    out2_d       = out2_q;
    out3_d       = out3_q;
    out4_d       = out4_q;
    out_valid_d  = out_valid_q;
    last_win_d   = last_win_q;
    frame_done_d = 1'b0;
    lb_we        = 1'b0;

    if (clear) begin
      state_d     = FILL;
      col_d       = '0;
      row_d       = '0;
      out_valid_d = 1'b0;
    end else begin
      frame_done_d = out_valid_q && bus.out_ready && last_win_q;

      if (out_valid_q && bus.out_ready) begin
        out_valid_d = 1'b0;
      end

      if (accept) begin
        if (col_q == COL_LAST) begin
          col_d   = '0;
          row_d   = (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
          state_d = (state_q == FILL) ? PAIR : FILL;
        end else begin
          col_d = col_q + 1'b1;
        end

        case (state_q)
          FILL: begin
            lb_we = 1'b1;
          end
          PAIR: begin
            if (!col_q[0]) begin
              // Left column of the window: park both left pixels.
              bot_left_d = bus.pixel_in;
              top_left_d = line_buf_q[col_q];
            end else begin
              // Right column completes the window; a same-edge load keeps out_valid high.
              out1_d      = top_left_q;
              out2_d      = line_buf_q[col_q];
              out3_d      = bot_left_q;
              out4_d      = bus.pixel_in;
              out_valid_d = 1'b1;
              last_win_d  = (row_q == ROW_LAST) && (col_q == COL_LAST);
            end
          end
          default: begin
            state_d = FILL;
          end
        endcase
      end
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= FILL;
      col_q        <= '0;
      row_q        <= '0;
      top_left_q   <= '0;
      bot_left_q   <= '0;
      out1_q       <= '0;
      out2_q       <= '0;
      out3_q       <= '0;
      out4_q       <= '0;
      out_valid_q  <= 1'b0;
      last_win_q   <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      col_q        <= col_d;
      row_q        <= row_d;
      top_left_q   <= top_left_d;
      bot_left_q   <= bot_left_d;
      out1_q       <= out1_d;
      out2_q       <= out2_d;
      out3_q       <= out3_d;
      out4_q       <= out4_d;
      out_valid_q  <= out_valid_d;
      last_win_q   <= last_win_d;
      frame_done_q <= frame_done_d;
    end
  end

  // Even-row storage.
  always_ff @(posedge clk) begin
    if (lb_we) begin
      line_buf_q[col_q] <= bus.pixel_in;
    end
  end

endmodule

// File: tb/tb_pool_window_buffer.sv
// tb_pool_window_buffer
//   Directed bench for pool_window_buffer on a 4x4 frame, 8-bit pixels.
//   Inputs change 1 time unit after each rising edge; outputs are sampled there.
module tb_pool_window_buffer;

  logic clk = 1'b0;
  logic rst_n;
  logic clear;

  int checks   = 0;
  int failures = 0;

  logic [7:0]  px [32];
  logic [31:0] exp_w;
  logic        exp_v;

  pool_window_buffer_if #(.DATA_WIDTH(8)) bus ();

  pool_window_buffer #(
    .DATA_WIDTH(8),
    .IMG_WIDTH (4),
    .IMG_HEIGHT(4)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .clear(clear),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic test_reset();
    rst_n = 1'b0;
    clear = 1'b0;
    bus.in_valid  = 1'b0;
    bus.pixel_in  = 8'h00;
    bus.out_ready = 1'b0;
    #12;
    checks++;
    if (bus.out_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_out_valid got=%b want=0", bus.out_valid); end
    checks++;
    if (bus.frame_done !== 1'b0) begin failures++; $display("[TB] FAIL reset_frame_done got=%b want=0", bus.frame_done); end
    checks++;
    if ({bus.out1, bus.out2, bus.out3, bus.out4} !== 32'h0) begin
      failures++; $display("[TB] FAIL reset_outs got=%h want=00000000", {bus.out1, bus.out2, bus.out3, bus.out4});
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (bus.in_ready !== 1'b1) begin failures++; $display("[TB] FAIL reset_in_ready got=%b want=1", bus.in_ready); end
    bus.out_ready = 1'b1;
  endtask

  task automatic test_basic_stream();
    for (int k = 0; k < 16; k++) px[k] = 8'(k + 1);
    for (int k = 0; k < 16; k++) begin
      bus.in_valid = 1'b1;
      bus.pixel_in = px[k];
      @(posedge clk); #1;
      exp_v = ((k / 4) % 2 == 1) && ((k % 4) % 2 == 1);
      checks++;
      if (bus.out_valid !== exp_v) begin failures++; $display("[TB] FAIL basic_valid k=%0d got=%b want=%b", k, bus.out_valid, exp_v); end
      checks++;
      if (bus.frame_done !== 1'b0) begin failures++; $display("[TB] FAIL basic_fd_early k=%0d got=%b want=0", k, bus.frame_done); end
      if (exp_v) begin
        exp_w = {px[k-5], px[k-4], px[k-1], px[k]};
        checks++;
        if ({bus.out1, bus.out2, bus.out3, bus.out4} !== exp_w) begin
          failures++; $display("[TB] FAIL basic_window k=%0d got=%h want=%h", k, {bus.out1, bus.out2, bus.out3, bus.out4}, exp_w);
        end
      end
    end
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (bus.frame_done !== 1'b1) begin failures++; $display("[TB] FAIL basic_frame_done got=%b want=1", bus.frame_done); end
    checks++;
    if (bus.out_valid !== 1'b0) begin failures++; $display("[TB] FAIL basic_valid_drop got=%b want=0", bus.out_valid); end
    @(posedge clk); #1;
    checks++;
    if (bus.frame_done !== 1'b0) begin failures++; $display("[TB] FAIL basic_fd_pulse got=%b want=0", bus.frame_done); end
  endtask

  task automatic test_backpressure();
    for (int k = 0; k < 16; k++) px[k] = 8'(8'h20 + k);
    bus.out_ready = 1'b0;
    for (int k = 0; k < 6; k++) begin
      bus.in_valid = 1'b1;
      bus.pixel_in = px[k];
      @(posedge clk); #1;
    end
    // Pixel 7 offered while the first window is held.
    bus.pixel_in = px[6];
    for (int s = 0; s < 4; s++) begin
      checks++;
      if (bus.in_ready !== 1'b0) begin failures++; $display("[TB] FAIL bp_in_ready s=%0d got=%b want=0", s, bus.in_ready); end
      checks++;
      if (bus.out_valid !== 1'b1) begin failures++; $display("[TB] FAIL bp_valid s=%0d got=%b want=1", s, bus.out_valid); end
      checks++;
      if ({bus.out1, bus.out2, bus.out3, bus.out4} !== 32'h20_21_24_25) begin
        failures++; $display("[TB] FAIL bp_hold s=%0d got=%h want=20212425", s, {bus.out1, bus.out2, bus.out3, bus.out4});
      end
      @(posedge clk); #1;
    end
    bus.out_ready = 1'b1;
    #1;
    checks++;
    if (bus.in_ready !== 1'b1) begin failures++; $display("[TB] FAIL bp_release got=%b want=1", bus.in_ready); end
    for (int k = 6; k < 16; k++) begin
      bus.in_valid = 1'b1;
      bus.pixel_in = px[k];
      @(posedge clk); #1;
      exp_v = ((k / 4) % 2 == 1) && ((k % 4) % 2 == 1);
      checks++;
      if (bus.out_valid !== exp_v) begin failures++; $display("[TB] FAIL bp_valid k=%0d got=%b want=%b", k, bus.out_valid, exp_v); end
      if (exp_v) begin
        exp_w = {px[k-5], px[k-4], px[k-1], px[k]};
        checks++;
        if ({bus.out1, bus.out2, bus.out3, bus.out4} !== exp_w) begin
          failures++; $display("[TB] FAIL bp_window k=%0d got=%h want=%h", k, {bus.out1, bus.out2, bus.out3, bus.out4}, exp_w);
        end
      end
    end
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (bus.frame_done !== 1'b1) begin failures++; $display("[TB] FAIL bp_frame_done got=%b want=1", bus.frame_done); end
  endtask

  task automatic test_signed();
    for (int k = 0; k < 16; k++) px[k] = 8'(8'h40 + k);
    px[0] = 8'h85; px[1] = 8'h03; px[4] = 8'h7F; px[5] = 8'h80;
    for (int k = 0; k < 16; k++) begin
      bus.in_valid = 1'b1;
      bus.pixel_in = px[k];
      @(posedge clk); #1;
      if (k == 5) begin
        checks++;
        if (bus.out_valid !== 1'b1) begin failures++; $display("[TB] FAIL signed_valid got=%b want=1", bus.out_valid); end
        checks++;
        if ({bus.out1, bus.out2, bus.out3, bus.out4} !== 32'h85_03_7F_80) begin
          failures++; $display("[TB] FAIL signed_window got=%h want=85037f80", {bus.out1, bus.out2, bus.out3, bus.out4});
        end
      end
    end
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_frame();
    for (int k = 0; k < 7; k++) begin
      bus.in_valid = 1'b1;
      bus.pixel_in = 8'(8'hA0 + k);
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    rst_n = 1'b0;
    #2;
    checks++;
    if ({bus.out1, bus.out2, bus.out3, bus.out4} !== 32'h0) begin
      failures++; $display("[TB] FAIL midrst_outs got=%h want=00000000", {bus.out1, bus.out2, bus.out3, bus.out4});
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    for (int k = 0; k < 16; k++) px[k] = 8'(k + 1);
    for (int k = 0; k < 16; k++) begin
      bus.in_valid = 1'b1;
      bus.pixel_in = px[k];
      @(posedge clk); #1;
      exp_v = ((k / 4) % 2 == 1) && ((k % 4) % 2 == 1);
      checks++;
      if (bus.out_valid !== exp_v) begin failures++; $display("[TB] FAIL midrst_valid k=%0d got=%b want=%b", k, bus.out_valid, exp_v); end
      if (exp_v) begin
        exp_w = {px[k-5], px[k-4], px[k-1], px[k]};
        checks++;
        if ({bus.out1, bus.out2, bus.out3, bus.out4} !== exp_w) begin
          failures++; $display("[TB] FAIL midrst_window k=%0d got=%h want=%h", k, {bus.out1, bus.out2, bus.out3, bus.out4}, exp_w);
        end
      end
    end
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (bus.frame_done !== 1'b1) begin failures++; $display("[TB] FAIL midrst_frame_done got=%b want=1", bus.frame_done); end
  endtask

  task automatic test_clear();
    for (int k = 0; k < 9; k++) begin
      bus.in_valid = 1'b1;
      bus.pixel_in = 8'(k + 1);
      @(posedge clk); #1;
    end
    // Pixel 10 arrives together with clear and must be dropped.
    bus.pixel_in = 8'd10;
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    checks++;
    if (bus.out_valid !== 1'b0) begin failures++; $display("[TB] FAIL clear_valid got=%b want=0", bus.out_valid); end
    for (int k = 0; k < 16; k++) px[k] = 8'(101 + k);
    for (int k = 0; k < 16; k++) begin
      bus.in_valid = 1'b1;
      bus.pixel_in = px[k];
      @(posedge clk); #1;
      exp_v = ((k / 4) % 2 == 1) && ((k % 4) % 2 == 1);
      checks++;
      if (bus.out_valid !== exp_v) begin failures++; $display("[TB] FAIL clear_valid k=%0d got=%b want=%b", k, bus.out_valid, exp_v); end
      if (exp_v) begin
        exp_w = {px[k-5], px[k-4], px[k-1], px[k]};
        checks++;
        if ({bus.out1, bus.out2, bus.out3, bus.out4} !== exp_w) begin
          failures++; $display("[TB] FAIL clear_window k=%0d got=%h want=%h", k, {bus.out1, bus.out2, bus.out3, bus.out4}, exp_w);
        end
      end
    end
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (bus.frame_done !== 1'b1) begin failures++; $display("[TB] FAIL clear_frame_done got=%b want=1", bus.frame_done); end
  endtask

  task automatic test_back_to_back();
    int idx, cyc, wins, fd, j;
    logic give;
    idx = 0; cyc = 0; wins = 0; fd = 0;
    for (int k = 0; k < 32; k++) px[k] = 8'(k + 1);
    while (idx < 32 && cyc < 400) begin
      // The first pixel of frame 2 is forced right after the last of frame 1.
      give = (idx == 16) || ($urandom_range(0, 3) != 0);
      bus.in_valid = give;
      bus.pixel_in = give ? px[idx] : 8'h00;
      @(posedge clk); #1;
      cyc++;
      exp_v = 1'b0;
      if (give) begin
        j = idx % 16;
        exp_v = ((j / 4) % 2 == 1) && ((j % 4) % 2 == 1);
        if (exp_v) exp_w = {px[idx-5], px[idx-4], px[idx-1], px[idx]};
        idx++;
      end
      checks++;
      if (bus.out_valid !== exp_v) begin failures++; $display("[TB] FAIL b2b_valid idx=%0d got=%b want=%b", idx, bus.out_valid, exp_v); end
      if (bus.out_valid === 1'b1) wins++;
      if (exp_v) begin
        checks++;
        if ({bus.out1, bus.out2, bus.out3, bus.out4} !== exp_w) begin
          failures++; $display("[TB] FAIL b2b_window idx=%0d got=%h want=%h", idx, {bus.out1, bus.out2, bus.out3, bus.out4}, exp_w);
        end
      end
      if (bus.frame_done === 1'b1) fd++;
    end
    checks++;
    if (idx != 32) begin failures++; $display("[TB] FAIL b2b_timeout got=%0d want=32", idx); end
    bus.in_valid = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
      if (bus.frame_done === 1'b1) fd++;
    end
    checks++;
    if (wins != 8) begin failures++; $display("[TB] FAIL b2b_windows got=%0d want=8", wins); end
    checks++;
    if (fd != 2) begin failures++; $display("[TB] FAIL b2b_frame_done got=%0d want=2", fd); end
  endtask

  initial begin
    test_reset();
    test_basic_stream();
    test_backpressure();
    test_signed();
    test_reset_mid_frame();
    test_clear();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
